seq_subtractor: RTL

Multi-cycle, digit-serial 16-bit subtractor producing the difference word and status flags consumed by the `comparator` block (its `IN` port), which derives `lt`/`gt`/`eq` from it. It is the producing end of the comparator's input interface in the lab ALU datapath. It trades the wide combinational borrow chain for a small adder, run over several cycles under a start/done handshake.

---
 rtl/alu_pkg.sv | 16 +
 rtl/digit_adder.sv | 15 +
 rtl/seq_subtractor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath package: FSM state encoding and saturation limits.
// Reused by seq_subtractor, comparator and later ALU blocks.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALU_W = 16;

    localparam logic [ALU_W-1:0] SAT_POS = {1'b0, {(ALU_W-1){1'b1}}};
    localparam logic [ALU_W-1:0] SAT_NEG = {1'b1, {(ALU_W-1){1'b0}}};

endpackage

// File: rtl/digit_adder.sv
// Combinational W-bit adder with carry-in and carry-out.
// One digit slice of the serial subtractor.
module digit_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/seq_subtractor.sv
// Digit-serial A - B: one DIGIT_W slice per cycle, start/done handshake.
// Optional macro SEQ_SUB_SAT_EN clamps OUT on signed overflow.
module seq_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OUT,
    output logic             c,
    output logic             v,
    output logic             busy,
    output logic             done
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t state, state_n;

    logic [WIDTH-1:0]         ra;
    logic [WIDTH-1:0]         rb;
    logic [WIDTH-DIGIT_W-1:0] acc;
    logic                     cy;
    logic [CW-1:0]            cnt;

    logic [DIGIT_W-1:0] d;
    logic               cy_n;
    logic               last;
    logic               ovf;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   res_q;

    digit_adder #(.W(DIGIT_W)) u_add (
        .a  (ra[DIGIT_W-1:0]),
        .b  (rb[DIGIT_W-1:0]),
        .ci (cy),
        .s  (d),
        .co (cy_n)
    );

    assign last = (cnt == CW'(N - 1));
    assign res  = {d, acc};

    // rb holds ~B, so equal addend signs means A and B differ in sign.
    assign ovf = (ra[DIGIT_W-1] == rb[DIGIT_W-1]) &&
                 (d[DIGIT_W-1] != ra[DIGIT_W-1]);

`ifdef SEQ_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_P = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_N = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of A when the final digit overflows.
    always_comb begin
        res_q = res;
        if (ovf)
            res_q = ra[DIGIT_W-1] ? SAT_N : SAT_P;
    end
`else
    assign res_q = res;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Operand shift registers, digit accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            acc <= '0;
            cy  <= 1'b0;
            cnt <= '0;
            OUT <= '0;
            c   <= 1'b0;
            v   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                ra  <= A;
                rb  <= ~B;
                cy  <= 1'b1;
                cnt <= '0;
            end
        end else if (state == RUN) begin
            ra  <= ra >> DIGIT_W;
            rb  <= rb >> DIGIT_W;
            acc <= res[WIDTH-1:DIGIT_W];
            cy  <= cy_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                OUT <= res_q;
                c   <= cy_n;
                v   <= ovf;
            end
        end
    end

endmodule
